fa4_operand_loader: RTL
=======================

Name: fa4_operand_loader

Overview:
- Front-end sequencer for the 4-bit adder on the board.
- Takes a 4-bit operand from slide switches and a raw push-button. Debounces the button and loads operand A, then operand B, into registers that drive the adder's a/b inputs.
- Captures the adder's 4-bit sum (modulo 16, carry discarded) into a result register for the LED display.
- Sits directly upstream of the adder and also consumes its output.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clocks the synchronized button must differ from its debounced level before that level changes (10 ms at 100 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw, asynchronous, bouncing push-button (1 = pressed).
- clr  input  1  synchronous clear, active-high, level.
- sw  input  4  operand value from the slide switches.
- sum_in  input  4  sum returned from the adder (a + b mod 16).
- op_a  output  4  operand A, drives adder a.
- op_b  output  4  operand B, drives adder b.
- result  output  4  captured sum.
- result_valid  output  1  high while result holds a sum for the current op_a/op_b.
- state  output  2  FSM state for the debug LEDs: 00 LOAD_A, 01 LOAD_B, 10 CALC, 11 SHOW.

Behaviour:
- Reset (rst_n low, asynchronous):
  - op_a = 0, op_b = 0, result = 0, result_valid = 0, state = LOAD_A.
  - Synchronizer flops, debounced level and debounce counter all cleared.
  - Deassertion takes effect on the next rising edge.
- Synchronizer: btn passes through 2 flops to give btn_s; btn is never used unsynchronized.
- Debounce:
  - Counter increments each cycle btn_s != btn_db.
  - The cycle the counter equals DEBOUNCE_CYCLES-1 with btn_s still different: btn_db <= btn_s and the counter resets to 0.
  - Any cycle with btn_s == btn_db: counter <= 0.
  - Glitches shorter than DEBOUNCE_CYCLES clocks never change btn_db.
- Press:
  - press = btn_db AND NOT btn_db_q, where btn_db_q is btn_db delayed 1 clock. This is a single-cycle pulse.
  - A clean press seen high at clock edge k gives press high during the cycle after edge k+1+DEBOUNCE_CYCLES.
  - Holding btn gives exactly one press; the button must release (debounced) before the next press.
- FSM transitions:
  - LOAD_A: on press, op_a <= sw, go to LOAD_B.
  - LOAD_B: on press, op_b <= sw, go to CALC.
  - CALC: unconditional, 1 cycle. result <= sum_in, result_valid <= 1, go to SHOW. A press in CALC is ignored (it cannot occur when DEBOUNCE_CYCLES >= 1).
  - SHOW: hold all outputs. On press: op_a <= sw, result_valid <= 0, go to LOAD_B. op_b and result hold their old values until overwritten.
- Timing:
  - Latency from the press that loads B to result_valid high is 2 clocks: op_b updates at edge n, result captured at edge n+1.
  - The adder is combinational, so sum_in is stable 1 cycle after op_b changes.
- Arithmetic: the block performs no arithmetic. result is exactly sum_in as sampled in CALC. Wrap-around is the adder's mod-16 behaviour and is passed through unchanged.
- Outputs: op_a, op_b, result, result_valid and state are all registered; no combinational path from inputs to outputs.
- clr:
  - Synchronous, higher priority than press.
  - op_a, op_b, result <= 0; result_valid <= 0; state <= LOAD_A.
  - The debounce logic is not cleared, so a button held across clr does not generate a new press.
- Simultaneous events:
  - clr together with press: clr wins and the press is dropped.
  - rst_n overrides everything in any state, including mid-debounce and CALC.
- sw is sampled only in the press cycle; changes at any other time have no effect.

Test Plan (DEBOUNCE_CYCLES = 4, real 4-bit adder model on op_a/op_b -> sum_in):
1. Reset check: assert rst_n low mid-cycle -> all outputs 0 and state = 00 immediately, without waiting for a clock edge. Release, wait 10 clocks, no btn -> outputs unchanged.
2. Basic add:
   - sw = 3, clean press -> op_a = 3, state = 01.
   - sw = 5, press -> op_b = 5; 2 clocks later result = 8, result_valid = 1, state = 11.
   - Check press timing: pulse appears in the cycle after edge k+1+4.
3. Wrap: A = 9, B = 9 -> result = 2, result_valid = 1. Then sw = 4, press in SHOW -> op_a = 4, result_valid = 0, state = 01.
4. Bounce rejection:
   - btn toggling with high/low widths of 1-3 clocks for 30 clocks, then held high 10 clocks -> exactly one press and one operand load.
   - A 3-clock glitch alone -> no state change.
5. Button held: btn held high 100 clocks -> only one load (state LOAD_A -> LOAD_B, not on to CALC).
6. clr and reset mid-operation:
   - clr asserted in LOAD_B (op_a = 7) -> next edge all registers 0, state = 00.
   - clr coincident with press -> press ignored.
   - rst_n low during CALC -> result = 0, result_valid = 0.

Source files
------------

// File: rtl/fa4_operand_loader.sv
// Operand sequencer for the board's 4-bit adder: debounces the push-button,
// loads operand A then B from the switches, and captures the adder's sum.
module fa4_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       clr,
  input  logic [3:0] sw,
  input  logic [3:0] sum_in,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] result,
  output logic       result_valid,
  output logic [1:0] state
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  logic          btn_meta;
  logic          btn_s;
  logic          btn_db;
  logic          btn_db_q;
  logic          press;
  logic [CW-1:0] db_cnt;

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [3:0]    res_q, res_d;
  logic          valid_q, valid_d;

  // The debounced level only follows btn_s after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles; clr deliberately leaves this path untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;
    if (clr) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (press) begin
            a_d     = sw;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_d     = sw;
            state_d = CALC;
          end
        end
        CALC: begin
          res_d   = sum_in;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          if (press) begin
            a_d     = sw;
            valid_d = 1'b0;
            state_d = LOAD_B;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign op_a         = a_q;
  assign op_b         = b_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule
